// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse delay path.
//   TS_W      : default timestamp width
//   MIN_DELAY : smallest rise delay the scheduler can honour
//   ts_t      : timestamp type
//   ts_before : modular "a is earlier than b" compare over the low w bits
package pulse_pkg;

    localparam int TS_W      = 32;
    localparam int MIN_DELAY = 3;

    typedef logic [TS_W-1:0] ts_t;

    // The difference is shifted up so that bit w-1 lands in the sign
    // position. Wrap is then harmless as long as the two times are less
    // than half the counter range apart.
    function automatic logic ts_before(input ts_t a, input ts_t b, input int unsigned w);
        logic signed [TS_W-1:0] diff;
        diff = signed'((a - b) << (TS_W - w));
        return (diff < 0);
    endfunction

endpackage

// File: rtl/pulse_ts_fifo.sv
// Synchronous first-word-fall-through FIFO of timestamps.
//   clk_i, reset_i : clock, synchronous active-high reset
//   flush          : empties the FIFO on the next edge
//   push, din      : write request and data (ignored when full unless popping)
//   pop            : consume the head (ignored when empty)
//   dout           : current head, valid whenever empty is low
//   full, empty    : occupancy flags
//   count          : current occupancy
module pulse_ts_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = pulse_pkg::TS_W
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   flush,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    import pulse_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign do_push = push && !flush && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (reset_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pulse_queue_delay.sv
// Delays each rising edge of inp_i by DELAY ticks and emits a WIDTH-tick
// pulse on out_o. Pending pulses are held as rise timestamps in a queue.
//   clk_i, reset_i    : clock, synchronous active-high reset
//   inp_i             : pulse input, rising edges are scheduled
//   enable_i          : low flushes the block and holds it idle
//   out_o             : delayed, reshaped pulse
//   DELAY/DELAY_WSTB  : rise delay and its write strobe
//   WIDTH/WIDTH_WSTB  : pulse width and its write strobe
//   QUEUE             : queue occupancy
//   DROPPED           : count of rejected input edges
//   ERR_OVERFLOW      : sticky, an edge was rejected on a full queue
module pulse_queue_delay #(
    parameter int QUEUE_DEPTH = 16,
    parameter int TS_W        = pulse_pkg::TS_W
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         inp_i,
    input  logic                         enable_i,
    output logic                         out_o,
    input  logic [TS_W-1:0]              DELAY,
    input  logic                         DELAY_WSTB,
    input  logic [TS_W-1:0]              WIDTH,
    input  logic                         WIDTH_WSTB,
    output logic [$clog2(QUEUE_DEPTH):0] QUEUE,
    output logic [31:0]                  DROPPED,
    output logic                         ERR_OVERFLOW
);
    import pulse_pkg::*;

    function automatic logic [TS_W-1:0] sat_floor(input logic [TS_W-1:0] v,
                                                  input logic [TS_W-1:0] lo);
        return (v < lo) ? lo : v;
    endfunction

    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] delay_q;
    logic [TS_W-1:0] width_q;
    logic [TS_W-1:0] d_eff;
    logic [TS_W-1:0] w_eff;
    logic [TS_W-1:0] last_fall;
    logic [TS_W-1:0] cnt;
    logic [TS_W-1:0] head;
    logic            lf_vld;
    logic            inp_p0;
    logic            en_p0;
    logic            flush;
    logic            rise;
    logic            late;
    logic            pop;
    logic            push;
    logic            full;
    logic            empty;

    assign d_eff = sat_floor(delay_q, TS_W'(MIN_DELAY));
    assign w_eff = sat_floor(width_q, TS_W'(1));

    // Disable and any config write both behave as a flush cycle.
    assign flush = !enable_i || DELAY_WSTB || WIDTH_WSTB;
    assign rise  = inp_i && !inp_p0 && !flush;
    assign late  = lf_vld && ts_before(ts_t'(ts), ts_t'(last_fall), TS_W);
    assign pop   = !empty && (head == ts) && !flush;
    assign push  = rise && !late && (!full || pop);

    pulse_ts_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .W     (TS_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .din     (ts + d_eff),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (QUEUE)
    );

    // Stage p0: edge sample, scheduling, output shaping and status.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ts           <= '0;
            inp_p0       <= 1'b0;
            en_p0        <= 1'b0;
            delay_q      <= '0;
            width_q      <= '0;
            out_o        <= 1'b0;
            cnt          <= '0;
            lf_vld       <= 1'b0;
            DROPPED      <= '0;
            ERR_OVERFLOW <= 1'b0;
        end else begin
            ts     <= ts + TS_W'(1);
            inp_p0 <= inp_i;
            en_p0  <= enable_i;
            if (DELAY_WSTB) delay_q <= DELAY;
            if (WIDTH_WSTB) width_q <= WIDTH;

            if (flush) begin
                out_o  <= 1'b0;
                cnt    <= '0;
                lf_vld <= 1'b0;
            end else begin
                // A head maturing on the last high cycle reloads the
                // counter, so abutting pulses merge without a gap.
                if (pop) begin
                    out_o <= 1'b1;
                    cnt   <= w_eff;
                end else if (cnt > TS_W'(1)) begin
                    cnt <= cnt - TS_W'(1);
                end else begin
                    out_o <= 1'b0;
                    cnt   <= '0;
                end
                // Once ts reaches last_fall the spacing guard has expired;
                // dropping it then keeps a stale value from aliasing after
                // the timestamp wraps.
                if (push) begin
                    last_fall <= ts + w_eff;
                    lf_vld    <= 1'b1;
                end else if (lf_vld && (ts == last_fall)) begin
                    lf_vld <= 1'b0;
                end
            end

            if (DELAY_WSTB || WIDTH_WSTB || (enable_i && !en_p0)) begin
                DROPPED      <= '0;
                ERR_OVERFLOW <= 1'b0;
            end else if (rise && !push) begin
                DROPPED <= DROPPED + 32'd1;
                if (!late) ERR_OVERFLOW <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_queue_delay.sv
module tb_pulse_queue_delay;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inp = 1'b0;
    logic        en = 1'b0;
    logic        dly_wstb = 1'b0;
    logic        wid_wstb = 1'b0;
    logic [31:0] dly = '0;
    logic [31:0] wid = '0;
    logic        use_w = 1'b0;

    logic        out_d, out_w, err_d, err_w;
    logic [2:0]  q_d;
    logic [4:0]  q_w;
    logic [31:0] drop_d, drop_w;

    logic        out_a, err_a;
    logic [4:0]  q_a;
    logic [31:0] drop_a;

    assign out_a  = use_w ? out_w : out_d;
    assign err_a  = use_w ? err_w : err_d;
    assign q_a    = use_w ? q_w : {2'b00, q_d};
    assign drop_a = use_w ? drop_w : drop_d;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model, in absolute time since reset (no wrap).
    longint m_ts, m_lf, m_hi_end, m_d, m_w;
    longint m_q[$];
    bit     m_lf_vld, m_prev_inp, m_prev_en, m_out, m_err;
    int     m_drop;

    always #5 clk = ~clk;

    pulse_queue_delay #(.QUEUE_DEPTH(4), .TS_W(32)) dut (
        .clk_i(clk), .reset_i(rst), .inp_i(inp), .enable_i(en), .out_o(out_d),
        .DELAY(dly), .DELAY_WSTB(dly_wstb), .WIDTH(wid), .WIDTH_WSTB(wid_wstb),
        .QUEUE(q_d), .DROPPED(drop_d), .ERR_OVERFLOW(err_d)
    );

    pulse_queue_delay #(.QUEUE_DEPTH(16), .TS_W(8)) dut_w (
        .clk_i(clk), .reset_i(rst), .inp_i(inp), .enable_i(en), .out_o(out_w),
        .DELAY(dly[7:0]), .DELAY_WSTB(dly_wstb), .WIDTH(wid[7:0]), .WIDTH_WSTB(wid_wstb),
        .QUEUE(q_w), .DROPPED(drop_w), .ERR_OVERFLOW(err_w)
    );

    task automatic model_edge();
        longint t, de, we;
        int     depth;
        bit     fl, rise, clr;
        t     = m_ts;
        depth = use_w ? 16 : 4;
        de    = (m_d < 3) ? 3 : m_d;
        we    = (m_w < 1) ? 1 : m_w;
        fl    = !en || dly_wstb || wid_wstb;
        rise  = inp && !m_prev_inp && !fl;
        clr   = dly_wstb || wid_wstb || (en && !m_prev_en);
        if (fl) begin
            m_q.delete();
            m_hi_end = -1;
            m_lf_vld = 0;
        end else if (m_q.size() > 0 && m_q[0] == t) begin
            void'(m_q.pop_front());
            m_hi_end = t + we - 1;
        end
        if (rise) begin
            if (m_lf_vld && t < m_lf) begin
                m_drop++;
            end else if (m_q.size() >= depth) begin
                m_drop++;
                m_err = 1;
            end else begin
                m_q.push_back(t + de);
                m_lf     = t + we;
                m_lf_vld = 1;
            end
        end
        if (clr) begin
            m_drop = 0;
            m_err  = 0;
        end
        m_out = !fl && (t <= m_hi_end);
        if (dly_wstb) m_d = longint'(dly);
        if (wid_wstb) m_w = longint'(wid);
        m_prev_inp = inp;
        m_prev_en  = en;
        m_ts++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic do_reset(input bit w);
        use_w = w; rst = 1'b1; inp = 1'b0; en = 1'b1; dly_wstb = 1'b0; wid_wstb = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ts = 0; m_q.delete(); m_hi_end = -1; m_lf = 0; m_lf_vld = 0;
        m_prev_inp = 0; m_prev_en = 0; m_out = 0; m_err = 0; m_drop = 0; m_d = 0; m_w = 0;
    endtask

    task automatic cfg(input int d, input int w);
        dly = 32'(d); wid = 32'(w); dly_wstb = 1'b1; wid_wstb = 1'b1;
        tick();
        dly_wstb = 1'b0; wid_wstb = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(0);
        n_chk++; if (out_a !== 1'b0) $display("FAIL reset_out: got %b want 0", out_a); else n_pass++;
        n_chk++; if (q_a !== 5'd0) $display("FAIL reset_queue: got %0d want 0", q_a); else n_pass++;
        n_chk++; if (drop_a !== 32'd0) $display("FAIL reset_dropped: got %0d want 0", drop_a); else n_pass++;
        n_chk++; if (err_a !== 1'b0) $display("FAIL reset_err: got %b want 0", err_a); else n_pass++;
    endtask

    task automatic test_single();
        longint t;
        bit     exp;
        int     peak;
        do_reset(0);
        cfg(10, 5);
        peak = 0;
        while (m_ts < 130) begin
            inp = (m_ts == 100);
            tick();
            t = m_ts - 1;
            if (int'(q_a) > peak) peak = int'(q_a);
            exp = (t >= 110) && (t <= 114);
            n_chk++; if (out_a !== exp) $display("FAIL single_out t=%0d: got %b want %b", t, out_a, exp); else n_pass++;
        end
        n_chk++; if (peak != 1) $display("FAIL single_peak: got %0d want 1", peak); else n_pass++;
        n_chk++; if (drop_a !== 32'd0) $display("FAIL single_dropped: got %0d want 0", drop_a); else n_pass++;
    endtask

    task automatic test_spacing();
        longint t;
        bit     exp;
        for (int v = 0; v < 2; v++) begin
            int gap;
            gap = (v == 0) ? 3 : 5;
            do_reset(0);
            cfg(10, 5);
            while (m_ts < 130) begin
                inp = (m_ts == 100) || (m_ts == 100 + gap);
                tick();
                t = m_ts - 1;
                exp = (t >= 110) && (t <= ((gap == 3) ? 114 : 119));
                n_chk++; if (out_a !== exp) $display("FAIL spacing%0d_out t=%0d: got %b want %b", gap, t, out_a, exp); else n_pass++;
            end
            n_chk++; if (drop_a !== ((gap == 3) ? 32'd1 : 32'd0)) $display("FAIL spacing%0d_dropped: got %0d", gap, drop_a); else n_pass++;
            n_chk++; if (err_a !== 1'b0) $display("FAIL spacing%0d_err: got %b want 0", gap, err_a); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        longint t;
        bit     exp;
        do_reset(0);
        cfg(1000, 1);
        while (m_ts < 1030) begin
            inp = (m_ts >= 4) && (m_ts <= 24) && (m_ts % 4 == 0);
            tick();
            t = m_ts - 1;
            exp = (t == 1004) || (t == 1008) || (t == 1012) || (t == 1016);
            n_chk++; if (out_a !== exp) $display("FAIL overflow_out t=%0d: got %b want %b", t, out_a, exp); else n_pass++;
            if (t == 24) begin
                n_chk++; if (q_a !== 5'd4) $display("FAIL overflow_queue: got %0d want 4", q_a); else n_pass++;
                n_chk++; if (drop_a !== 32'd2) $display("FAIL overflow_dropped: got %0d want 2", drop_a); else n_pass++;
                n_chk++; if (err_a !== 1'b1) $display("FAIL overflow_err: got %b want 1", err_a); else n_pass++;
            end
        end
        n_chk++; if (q_a !== 5'd0) $display("FAIL overflow_drain: got %0d want 0", q_a); else n_pass++;
    endtask

    task automatic test_enable();
        longint t;
        bit     exp;
        do_reset(0);
        cfg(20, 8);
        while (m_ts < 80) begin
            inp = (m_ts == 1) || (m_ts == 3) || (m_ts == 11) || (m_ts == 21);
            en  = !((m_ts >= 26) && (m_ts <= 29));
            tick();
            t = m_ts - 1;
            exp = (t >= 21) && (t <= 25);
            n_chk++; if (out_a !== exp) $display("FAIL enable_out t=%0d: got %b want %b", t, out_a, exp); else n_pass++;
            if (t == 27) begin
                n_chk++; if (q_a !== 5'd0) $display("FAIL enable_flush_queue: got %0d want 0", q_a); else n_pass++;
                n_chk++; if (drop_a !== 32'd1) $display("FAIL enable_hold_dropped: got %0d want 1", drop_a); else n_pass++;
            end
            if (t == 30) begin
                n_chk++; if (drop_a !== 32'd0) $display("FAIL enable_rise_clear: got %0d want 0", drop_a); else n_pass++;
            end
        end
    endtask

    task automatic test_clamp_and_wstb();
        longint t;
        bit     exp;
        do_reset(0);
        cfg(0, 0);
        while (m_ts < 60) begin
            inp = (m_ts == 50);
            tick();
            t = m_ts - 1;
            exp = (t == 53);
            n_chk++; if (out_a !== exp) $display("FAIL clamp_out t=%0d: got %b want %b", t, out_a, exp); else n_pass++;
        end
        do_reset(0);
        cfg(40, 4);
        while (m_ts < 70) begin
            inp = (m_ts == 5) || (m_ts == 7) || (m_ts == 10);
            dly_wstb = (m_ts == 15);
            tick();
            t = m_ts - 1;
            n_chk++; if (out_a !== 1'b0) $display("FAIL wstb_out t=%0d: got %b want 0", t, out_a); else n_pass++;
            if (t == 14) begin
                n_chk++; if (q_a !== 5'd2) $display("FAIL wstb_pre_queue: got %0d want 2", q_a); else n_pass++;
                n_chk++; if (drop_a !== 32'd1) $display("FAIL wstb_pre_dropped: got %0d want 1", drop_a); else n_pass++;
            end
            if (t == 15) begin
                n_chk++; if (q_a !== 5'd0) $display("FAIL wstb_queue: got %0d want 0", q_a); else n_pass++;
                n_chk++; if (drop_a !== 32'd0) $display("FAIL wstb_dropped: got %0d want 0", drop_a); else n_pass++;
            end
        end
        dly_wstb = 1'b0;
    endtask

    task automatic test_wrap();
        longint t;
        bit     exp;
        do_reset(1);
        cfg(10, 3);
        while (m_ts < 275) begin
            inp = (m_ts == 252) || (m_ts == 254) || (m_ts == 256);
            tick();
            t = m_ts - 1;
            exp = ((t >= 262) && (t <= 264)) || ((t >= 266) && (t <= 268));
            n_chk++; if (out_a !== exp) $display("FAIL wrap_out t=%0d: got %b want %b", t, out_a, exp); else n_pass++;
        end
        n_chk++; if (drop_a !== 32'd1) $display("FAIL wrap_dropped: got %0d want 1", drop_a); else n_pass++;
        n_chk++; if (q_a !== 5'd0) $display("FAIL wrap_queue: got %0d want 0", q_a); else n_pass++;
        use_w = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset(0);
        cfg(10, 5);
        while (m_ts < 33) begin
            inp = (m_ts == 20) || (m_ts == 22) || (m_ts == 26);
            tick();
        end
        n_chk++; if (out_a !== 1'b1) $display("FAIL midrst_pre_out: got %b want 1", out_a); else n_pass++;
        n_chk++; if (drop_a !== 32'd1) $display("FAIL midrst_pre_dropped: got %0d want 1", drop_a); else n_pass++;
        do_reset(0);
        n_chk++; if (out_a !== 1'b0) $display("FAIL midrst_out: got %b want 0", out_a); else n_pass++;
        n_chk++; if (q_a !== 5'd0) $display("FAIL midrst_queue: got %0d want 0", q_a); else n_pass++;
        n_chk++; if (drop_a !== 32'd0) $display("FAIL midrst_dropped: got %0d want 0", drop_a); else n_pass++;
        while (m_ts < 20) begin
            tick();
            n_chk++; if (out_a !== 1'b0) $display("FAIL midrst_idle t=%0d: got %b want 0", m_ts - 1, out_a); else n_pass++;
        end
    endtask

    task automatic test_random();
        longint t;
        for (int r = 0; r < 6; r++) begin
            do_reset(0);
            cfg(int'($urandom_range(0, 12)), int'($urandom_range(0, 6)));
            repeat (400) begin
                inp      = ($urandom_range(0, 99) < 40);
                en       = ($urandom_range(0, 99) >= 3);
                dly_wstb = ($urandom_range(0, 99) == 0);
                wid_wstb = ($urandom_range(0, 99) == 0);
                if (dly_wstb) dly = 32'($urandom_range(0, 12));
                if (wid_wstb) wid = 32'($urandom_range(0, 6));
                tick();
                t = m_ts - 1;
                n_chk++; if (out_a !== m_out) $display("FAIL rand_out r=%0d t=%0d: got %b want %b", r, t, out_a, m_out); else n_pass++;
                n_chk++; if (q_a !== 5'(m_q.size())) $display("FAIL rand_queue r=%0d t=%0d: got %0d want %0d", r, t, q_a, m_q.size()); else n_pass++;
                n_chk++; if (drop_a !== 32'(m_drop)) $display("FAIL rand_dropped r=%0d t=%0d: got %0d want %0d", r, t, drop_a, m_drop); else n_pass++;
                n_chk++; if (err_a !== m_err) $display("FAIL rand_err r=%0d t=%0d: got %b want %b", r, t, err_a, m_err); else n_pass++;
            end
            dly_wstb = 1'b0;
            wid_wstb = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_spacing();
        test_overflow();
        test_enable();
        test_clamp_and_wstb();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
